// File: rtl/wb_serial_master_pkg.sv
// Shared constants for wb_serial_master: command opcodes, response status codes,
// the control FSM state encoding and the status-selection helper.
package wb_serial_master_pkg;

  localparam logic [7:0] OP_WRITE    = 8'h01;
  localparam logic [7:0] OP_READ     = 8'h02;

  localparam logic [7:0] ST_WR_OK    = 8'h81;
  localparam logic [7:0] ST_RD_OK    = 8'h82;
  localparam logic [7:0] ST_BUS_ERR  = 8'hE1;
  localparam logic [7:0] ST_TIMEOUT  = 8'hE2;
  localparam logic [7:0] ST_BAD_OP   = 8'hEE;

  // Status byte plus up to four read-data bytes.
  localparam int RESP_W = 40;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  // err and rty both report as a bus error and take precedence over ack.
  function automatic logic [7:0] term_status(input logic err, input logic rty, input logic is_write);
    logic [7:0] st;
    if (err || rty) begin
      st = ST_BUS_ERR;
    end else if (is_write) begin
      st = ST_WR_OK;
    end else begin
      st = ST_RD_OK;
    end
    return st;
  endfunction

endpackage

// File: rtl/wb_serial_master_txser.sv
// Response serializer: loads a byte count and a 40-bit payload, then presents
// one byte at a time (MSB byte first) on a valid/ready handshake.
module wb_serial_master_txser
  import wb_serial_master_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              load,
  input  logic [2:0]        byte_count,
  input  logic [RESP_W-1:0] payload,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              last_hs
);

  logic [RESP_W-1:0] shift_r;
  logic [2:0]        remain_r;
  logic              valid_r;
  logic              hs_s;

  assign hs_s     = valid_r & tx_ready;
  assign last_hs  = hs_s & (remain_r == 3'd1);
  assign tx_data  = shift_r[RESP_W-1 -: 8];
  assign tx_valid = valid_r;

  // Shift register and byte countdown; data only moves on load or handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_r  <= '0;
      remain_r <= 3'd0;
      valid_r  <= 1'b0;
    end else if (load) begin
      shift_r  <= payload;
      remain_r <= byte_count;
      valid_r  <= (byte_count != 3'd0);
    end else if (hs_s) begin
      shift_r  <= {shift_r[RESP_W-9:0], 8'h00};
      remain_r <= remain_r - 3'd1;
      valid_r  <= (remain_r != 3'd1);
    end
  end

endmodule

// File: rtl/wb_serial_master.sv
// Byte-stream to Wishbone classic initiator: one read/write per command frame,
// one status/data response frame. Optional bus timeout: WB_SERIAL_MASTER_TIMEOUT_EN.
module wb_serial_master
  import wb_serial_master_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1023
)
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_stb_o,
  output logic                    wb_cyc_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i,
  output logic                    o_busy
);

  state_t                  state_r, state_nxt_s;
  logic [1:0]              cnt_r;
  logic                    rx_ready_r, busy_r, rx_ready_nxt_s, busy_nxt_s;
  logic                    rx_hs_s, op_valid_s, term_s, tmo_hit_s, load_s, last_hs_s;
  logic                    resp_loaded_r, op_write_r;
  logic [7:0]              status_r;
  logic [2:0]              resp_len_r;
  logic [DATA_WIDTH-1:0]   rdata_r, dat_r;
  logic [ADDR_WIDTH-1:0]   adr_r;
  logic                    cyc_r, we_r;
  logic [DATA_WIDTH/8-1:0] sel_r;

  assign rx_hs_s    = rx_valid & rx_ready_r;
  assign op_valid_s = (rx_data == OP_WRITE) || (rx_data == OP_READ);
  assign term_s     = cyc_r & (wb_ack_i | wb_err_i | wb_rty_i);

`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
  localparam int              TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_cnt_r;

  // Counter holds the number of strobed cycles so far, including the current one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == S_BUS) && !cyc_r) begin
      tmo_cnt_r <= TMO_W'(1);
    end else if (cyc_r) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  assign tmo_hit_s = cyc_r & ~term_s & (tmo_cnt_r == TMO_LIMIT);
`else
  logic unused_tmo_s;
  assign unused_tmo_s = |TIMEOUT_CYCLES;
  assign tmo_hit_s    = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (rx_hs_s) begin
          state_nxt_s = op_valid_s ? S_ADDR : S_RESP;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ADDR: begin
        if (rx_hs_s && (cnt_r == 2'd3)) begin
          state_nxt_s = op_write_r ? S_DATA : S_BUS;
        end else begin
          state_nxt_s = S_ADDR;
        end
      end
      S_DATA: begin
        if (rx_hs_s && (cnt_r == 2'd3)) begin
          state_nxt_s = S_BUS;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_BUS: begin
        if (term_s || tmo_hit_s) begin
          state_nxt_s = S_RESP;
        end else begin
          state_nxt_s = S_BUS;
        end
      end
      S_RESP: begin
        if (last_hs_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RESP;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM outputs: flags follow the next state so they are valid right after each edge.
  always_comb begin
    rx_ready_nxt_s = (state_nxt_s == S_IDLE) || (state_nxt_s == S_ADDR) || (state_nxt_s == S_DATA);
    busy_nxt_s     = (state_nxt_s != S_IDLE);
    load_s         = (state_r == S_RESP) && !resp_loaded_r;
  end

  // Registered handshake and busy flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_ready_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      rx_ready_r <= rx_ready_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  // Frame capture, bus cycle control and response status.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_r         <= 2'd0;
      op_write_r    <= 1'b0;
      adr_r         <= '0;
      dat_r         <= '0;
      rdata_r       <= '0;
      cyc_r         <= 1'b0;
      we_r          <= 1'b0;
      sel_r         <= '0;
      status_r      <= 8'h00;
      resp_len_r    <= 3'd0;
      resp_loaded_r <= 1'b0;
    end else begin
      resp_loaded_r <= (state_r == S_RESP);
      case (state_r)
        S_IDLE: begin
          if (rx_hs_s) begin
            cnt_r      <= 2'd0;
            op_write_r <= (rx_data == OP_WRITE);
            status_r   <= ST_BAD_OP;
            resp_len_r <= 3'd1;
          end
        end
        S_ADDR: begin
          if (rx_hs_s) begin
            adr_r <= {adr_r[ADDR_WIDTH-9:0], rx_data};
            cnt_r <= cnt_r + 2'd1;
          end
        end
        S_DATA: begin
          if (rx_hs_s) begin
            dat_r <= {dat_r[DATA_WIDTH-9:0], rx_data};
            cnt_r <= cnt_r + 2'd1;
          end
        end
        S_BUS: begin
          if (!cyc_r) begin
            cyc_r <= 1'b1;
            we_r  <= op_write_r;
            sel_r <= '1;
          end else if (term_s) begin
            cyc_r    <= 1'b0;
            we_r     <= 1'b0;
            sel_r    <= '0;
            status_r <= term_status(wb_err_i, wb_rty_i, op_write_r);
            if (wb_ack_i && !wb_err_i && !wb_rty_i && !op_write_r) begin
              rdata_r    <= wb_dat_i;
              resp_len_r <= 3'd5;
            end else begin
              resp_len_r <= 3'd1;
            end
          end else if (tmo_hit_s) begin
            cyc_r      <= 1'b0;
            we_r       <= 1'b0;
            sel_r      <= '0;
            status_r   <= ST_TIMEOUT;
            resp_len_r <= 3'd1;
          end
        end
        S_RESP: begin
          cnt_r <= 2'd0;
        end
        default: begin
          cnt_r <= 2'd0;
          cyc_r <= 1'b0;
        end
      endcase
    end
  end

  wb_serial_master_txser u_txser (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .load       (load_s),
    .byte_count (resp_len_r),
    .payload    ({status_r, rdata_r}),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .last_hs    (last_hs_s)
  );

  assign rx_ready = rx_ready_r;
  assign o_busy   = busy_r;
  assign wb_adr_o = adr_r;
  assign wb_dat_o = dat_r;
  assign wb_we_o  = we_r;
  assign wb_sel_o = sel_r;
  assign wb_cyc_o = cyc_r;
  assign wb_stb_o = cyc_r;

endmodule

// File: tb/tb_wb_serial_master.sv
// Directed bench for wb_serial_master with a small configurable Wishbone responder.
module tb_wb_serial_master;

  localparam int TMO = 16;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o, wb_cyc_o, wb_ack_i, wb_err_i, wb_rty_i;
  logic        o_busy;

  always #5 i_clk = ~i_clk;

  wb_serial_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .o_busy(o_busy)
  );

  // Responder: mode 0 ack, 1 err+ack, 2 rty, 3 silent; terminates after ack_wait wait states.
  int          resp_mode = 0;
  int          ack_wait  = 0;
  logic [31:0] rd_val    = 32'h0;
  int          wait_cnt  = 0;
  int          stb_total = 0;
  int          term_total = 0;
  logic [31:0] cap_adr = 32'h0, cap_dat = 32'h0;
  logic        cap_we = 1'b0;
  logic [3:0]  cap_sel = 4'h0;
  logic        hit_s;

  assign hit_s    = wb_cyc_o & wb_stb_o & (wait_cnt == ack_wait);
  assign wb_ack_i = hit_s & ((resp_mode == 0) || (resp_mode == 1));
  assign wb_err_i = hit_s & (resp_mode == 1);
  assign wb_rty_i = hit_s & (resp_mode == 2);
  assign wb_dat_i = (wb_ack_i && !wb_we_o) ? rd_val : 32'h0BADF00D;

  always @(posedge i_clk) begin
    if (wb_cyc_o && wb_stb_o) begin
      stb_total <= stb_total + 1;
      wait_cnt  <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
    if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i || wb_rty_i)) begin
      term_total <= term_total + 1;
      cap_adr    <= wb_adr_o;
      cap_dat    <= wb_dat_o;
      cap_we     <= wb_we_o;
      cap_sel    <= wb_sel_o;
    end
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      tick();
      n++;
    end
    check("rx_accept", 40'(rx_ready), 40'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] adr,
                            input logic [31:0] dat, input bit with_data);
    send_byte(op);
    for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8]);
    if (with_data) begin
      for (int i = 3; i >= 0; i--) send_byte(dat[i*8 +: 8]);
    end
  endtask

  task automatic wait_tx(output int lat);
    lat = 0;
    while (!tx_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  // Receive bytes first..n-1 of a payload; optionally check the idle state afterwards.
  task automatic recv(input int n, input logic [39:0] pl, input int first, input bit idle_chk);
    int w;
    tx_ready = 1'b1;
    for (int i = first; i < n; i++) begin
      w = 0;
      while (!tx_valid && w < 50) begin
        tick();
        w++;
      end
      check($sformatf("tx_valid%0d", i), 40'(tx_valid), 40'd1);
      check($sformatf("tx_byte%0d", i), 40'(tx_data), 40'(pl[39-8*i -: 8]));
      tick();
    end
    if (idle_chk) begin
      check("idle_rx_ready", 40'(rx_ready), 40'd1);
      check("idle_tx_valid", 40'(tx_valid), 40'd0);
      check("idle_busy", 40'(o_busy), 40'd0);
    end
  endtask

  initial begin
    int   lat, base_stb, base_term, n;
    logic [7:0] hold;
    bit   stable, seen;

    i_rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (3) tick();
    check("rst_rx_ready", 40'(rx_ready), 40'd0);
    check("rst_tx_valid", 40'(tx_valid), 40'd0);
    check("rst_cyc", 40'(wb_cyc_o), 40'd0);
    check("rst_stb", 40'(wb_stb_o), 40'd0);
    check("rst_sel", 40'(wb_sel_o), 40'd0);
    check("rst_busy", 40'(o_busy), 40'd0);
    i_rst = 1'b0;
    tick();
    check("post_rst_rx_ready", 40'(rx_ready), 40'd1);

    // Write, zero wait states: minimum turnaround.
    resp_mode = 0; ack_wait = 0;
    base_stb = stb_total; base_term = term_total;
    send_frame(8'h01, 32'h0000_0000, 32'h0000_0015, 1'b1);
    wait_tx(lat);
    check("wr_latency", 40'(lat), 40'd3);
    check("wr_stb_cycles", 40'(stb_total - base_stb), 40'd1);
    check("wr_terms", 40'(term_total - base_term), 40'd1);
    check("wr_adr", 40'(cap_adr), 40'h0);
    check("wr_dat", 40'(cap_dat), 40'h15);
    check("wr_we", 40'(cap_we), 40'd1);
    check("wr_sel", 40'(cap_sel), 40'hF);
    recv(1, {8'h81, 32'h0}, 0, 1'b1);

    // Read with 3 wait states.
    ack_wait = 3; rd_val = 32'h0000_002F;
    base_stb = stb_total;
    send_frame(8'h02, 32'h0000_0000, 32'h0, 1'b0);
    wait_tx(lat);
    check("rd_stb_cycles", 40'(stb_total - base_stb), 40'd4);
    check("rd_we", 40'(cap_we), 40'd0);
    check("rd_sel", 40'(cap_sel), 40'hF);
    recv(5, {8'h82, 32'h0000_002F}, 0, 1'b1);

    // err together with ack: status only.
    resp_mode = 1; ack_wait = 0; rd_val = 32'h1234_5678;
    send_frame(8'h02, 32'h0000_0040, 32'h0, 1'b0);
    wait_tx(lat);
    recv(1, {8'hE1, 32'h0}, 0, 1'b1);

    // rty on a write.
    resp_mode = 2;
    send_frame(8'h01, 32'h0000_0044, 32'h0000_00AA, 1'b1);
    wait_tx(lat);
    recv(1, {8'hE1, 32'h0}, 0, 1'b1);

    // Unknown opcode: no bus cycle.
    resp_mode = 0;
    base_stb = stb_total;
    send_byte(8'h7F);
    wait_tx(lat);
    recv(1, {8'hEE, 32'h0}, 0, 1'b1);
    check("badop_no_cyc", 40'(stb_total - base_stb), 40'd0);

    // Read with rx_valid held through BUS, then tx backpressure mid-response.
    ack_wait = 5; rd_val = 32'hA1B2_C3D4;
    base_stb = stb_total;
    send_frame(8'h02, 32'h0000_0010, 32'h0, 1'b0);
    rx_data = 8'h02; rx_valid = 1'b1; seen = 1'b0; n = 0;
    while (!tx_valid && n < 200) begin
      if (rx_ready) seen = 1'b1;
      tick();
      n++;
    end
    rx_valid = 1'b0;
    check("hold_rx_ready_low", 40'(seen), 40'd0);
    check("hold_stb_cycles", 40'(stb_total - base_stb), 40'd6);
    recv(1, {8'h82, 32'hA1B2_C3D4}, 0, 1'b0);
    tx_ready = 1'b0; hold = tx_data; stable = 1'b1;
    repeat (5) begin
      tick();
      if (tx_data !== hold || !tx_valid) stable = 1'b0;
    end
    check("bp_stable", 40'(stable), 40'd1);
    check("bp_held_byte", 40'(hold), 40'hA1);
    recv(5, {8'h82, 32'hA1B2_C3D4}, 1, 1'b1);

    // Silent responder.
    resp_mode = 3;
    base_stb = stb_total;
    send_frame(8'h02, 32'h0000_0100, 32'h0, 1'b0);
`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
    wait_tx(lat);
    check("tmo_stb_cycles", 40'(stb_total - base_stb), 40'(TMO));
    recv(1, {8'hE2, 32'h0}, 0, 1'b1);
    send_frame(8'h02, 32'h0000_0104, 32'h0, 1'b0);
    repeat (5) tick();
`else
    repeat (1000) tick();
    check("no_tmo_cyc_held", 40'(wb_cyc_o), 40'd1);
    check("no_tmo_tx_idle", 40'(tx_valid), 40'd0);
`endif

    // Reset while strobing.
    check("pre_rst_cyc", 40'(wb_cyc_o), 40'd1);
    i_rst = 1'b1;
    tick();
    check("mid_rst_cyc", 40'(wb_cyc_o), 40'd0);
    check("mid_rst_stb", 40'(wb_stb_o), 40'd0);
    i_rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (tx_valid) seen = 1'b1;
    end
    check("mid_rst_no_tx", 40'(seen), 40'd0);

    // Normal frame after the reset.
    resp_mode = 0; ack_wait = 1;
    send_frame(8'h01, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1);
    wait_tx(lat);
    check("post_adr", 40'(cap_adr), 40'h1234_5678);
    check("post_dat", 40'(cap_dat), 40'hDEAD_BEEF);
    check("post_we", 40'(cap_we), 40'd1);
    recv(1, {8'h81, 32'h0}, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
